// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, redirect, and decode-side queue head.
// master is the fetch unit; slave is the memory/decode environment around it.
interface if_fetch_queue_if #(
  parameter int XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [16:0]     id_ctrl_key;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_ctrl_key,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_ctrl_key,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: one outstanding imem request, 2-entry instruction queue,
// redirect flushes the queue and drops any in-flight response.
module if_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst_n,
  if_fetch_queue_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_addr;
  logic            drop;
  logic            req_q;
  logic [1:0]      count;
  logic [31:0]     q_instr [2];
  logic [XLEN-1:0] q_pc    [2];

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            pop;
  logic            push;
  logic            wr_slot;
  logic [1:0]      count_next;

  // Redirect outranks everything: it masks both the pop and the push of its cycle.
  always_comb begin
    redirect   = bus.redirect_valid;
    target     = {bus.redirect_pc[XLEN-1:2], 2'b00};
    pop        = (count != 2'd0) && bus.id_ready && !redirect;
    push       = (state == WAIT) && bus.imem_rvalid && !drop && !redirect;
    wr_slot    = pop ? (count == 2'd2) : (count == 2'd1);
    count_next = count;
    if (redirect)
      count_next = 2'd0;
    else if (push && !pop)
      count_next = count + 2'd1;
    else if (pop && !push)
      count_next = count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      drop     <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= target;
            req_addr <= target;
            state    <= REQ;
            req_q    <= 1'b1;
          end else if (count_next < 2'd2) begin
            req_addr <= fetch_pc;
            state    <= REQ;
            req_q    <= 1'b1;
          end
        end
        REQ: begin
          // The granted address is already committed, so a redirect only retargets fetch_pc.
          if (redirect) begin
            fetch_pc <= target;
            drop     <= 1'b1;
          end
          if (bus.imem_gnt) begin
            state <= WAIT;
            req_q <= 1'b0;
            if (!redirect && !drop)
              fetch_pc <= req_addr + XLEN'(4);
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            drop <= 1'b0;
            if (redirect) begin
              fetch_pc <= target;
              req_addr <= target;
              state    <= REQ;
              req_q    <= 1'b1;
            end else if (count_next < 2'd2) begin
              req_addr <= fetch_pc;
              state    <= REQ;
              req_q    <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (redirect) begin
            fetch_pc <= target;
            drop     <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 down before any push lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      q_pc[0]    <= '0;
      q_pc[1]    <= '0;
    end else begin
      count <= count_next;
      if (pop) begin
        q_instr[0] <= q_instr[1];
        q_pc[0]    <= q_pc[1];
      end
      if (push) begin
        q_instr[wr_slot] <= bus.imem_rdata;
        q_pc[wr_slot]    <= req_addr;
      end
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = req_addr;
  assign bus.id_valid    = (count != 2'd0);
  assign bus.id_instr    = q_instr[0];
  assign bus.id_pc       = q_pc[0];
  assign bus.id_ctrl_key = bus.id_valid ? {q_instr[0][31:25], q_instr[0][14:12], q_instr[0][6:0]}
                                        : 17'd0;

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch stage for the RV64 core, directly upstream of the control decoder. Generates fetch addresses and drives a request/grant/response handshake to instruction memory, with at most one request outstanding. Returned instructions are buffered in a 2-entry queue. The queue head is presented to decode together with the 17-bit decoder key {funct7, funct3, opcode}. Control transfers are handled by a redirect input that flushes the queue and discards any in-flight response.

## Interface
- XLEN, 64, PC/address width
- RESET_PC, 64'h0, first fetch address after reset
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- imem_req  out  1  fetch request; registered
- imem_addr  out  XLEN  fetch address; stable while imem_req=1 and imem_gnt=0
- imem_gnt  in  1  request accepted this cycle when imem_req=1
- imem_rvalid  in  1  response valid; arrives ≥1 cycle after the grant cycle
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- redirect_valid  in  1  control transfer; flush and refetch
- redirect_pc  in  XLEN  target; bits [1:0] ignored and treated as 0
- id_valid  out  1  queue head valid
- id_ready  in  1  decode accepts head; pop when id_valid & id_ready
- id_instr  out  32  head instruction
- id_pc  out  XLEN  head PC
- id_ctrl_key  out  17  {id_instr[31:25], id_instr[14:12], id_instr[6:0]}; all-zero when id_valid=0, so decode emits a null control word

## Operation
- State: FSM {IDLE, REQ, WAIT}; fetch_pc (next address); req_addr (address of the current/outstanding request); drop flag; queue count (0..2) with 2 entries of {instr, pc}.
- FSM transitions:
  - IDLE→REQ when count_next < 2, where count_next is the count after this cycle's pop/flush. Capture req_addr ← fetch_pc.
  - REQ: imem_req=1, imem_addr=req_addr. On gnt: go to WAIT; fetch_pc ← req_addr+4.
  - WAIT: on rvalid, if drop=1, discard the data and clear drop. Otherwise push {imem_rdata, req_addr}. Next state is REQ (with req_addr ← fetch_pc) if count_next < 2, else IDLE.
- One slot is always reserved for the outstanding request: REQ is entered only when count_next ≤ 1. A push therefore never overflows.
- Redirect is highest priority.
  - Queue cleared (count←0); any same-cycle pop or push is ignored.
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - In IDLE: req_addr ← redirected fetch_pc; go to REQ.
  - In REQ: request stays asserted with the unchanged req_addr until gnt; drop←1. After gnt, fetch_pc keeps the redirect target (no +4).
  - In WAIT: drop←1. If rvalid occurs in the same cycle, that response is dropped, drop stays 0, and the FSM goes to REQ with the target.
- Arithmetic: fetch_pc+4 wraps modulo 2^XLEN.
- Queue: FIFO order; simultaneous push and pop when count=2 cannot occur (reservation rule). Push and pop in the same cycle leaves count unchanged.

## Timing
- Reset values (rst_n=0, asynchronous):
  - State: FSM=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, drop=0, count=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_ctrl_key=0.
- First request: imem_req=1 in the 2nd rising edge's cycle after rst_n deasserts (IDLE→REQ takes one cycle).
- Latency: gnt in cycle N, rvalid in cycle M>N; id_valid=1 in cycle M+1 (registered push).
- Peak throughput with zero-wait memory (gnt same cycle, rvalid next): one instruction per 2 cycles.
- Backpressure: with id_ready=0 the queue fills to 2 and imem_req stays 0. The request restarts the cycle after the first pop.
- id_* outputs are driven from queue registers and are stable while id_valid=1 and id_ready=0.
- Reset mid-transaction: all state is cleared immediately. A late rvalid after reset while the FSM is in IDLE or REQ is ignored.

## Test plan
- Reset/startup: RESET_PC=0x1000, hold rst_n=0 → all outputs at their reset values. Release with zero-wait memory → imem_addr sequence 0x1000, 0x1004, 0x1008. id_pc follows the same sequence, with id_ctrl_key = decoder key of each word (e.g. 0x00B50533 → key 17'b0000000_000_0110011).
- Backpressure: id_ready=0 → count reaches 2, imem_req=0 thereafter. Raise id_ready for one cycle → one pop, imem_req=1 the next cycle, addr = next sequential PC.
- Redirect in WAIT: gnt for 0x1008, redirect_pc=0x2002 before rvalid → that response is discarded. Next request is to 0x2000, id_valid=0 until the 0x2000 data arrives.
- Redirect in REQ without gnt: imem_addr stays 0x100C until gnt; its response is dropped; next request is to the target.
- Stall + redirect together: queue full, id_ready=1, redirect_valid=1 in the same cycle → count=0, no pop is counted, id_valid=0 next cycle.
- Reset mid-WAIT: assert rst_n=0 while WAIT → immediate reset values. A stray rvalid after release does not push; the fetch restarts at RESET_PC.
